// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank and its read ports.
package reg_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port: one-cycle latency, write-through bypass, clr reads as zero.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic             wr_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    logic [WIDTH-1:0] rdata_d, rdata_q;
    logic             rvalid_d, rvalid_q;

    // wr_en is already qualified by clr and the hardwired-zero register.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (re) begin
            if (clr) begin
                rdata_d = '0;
            end else if (wr_en && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = regs[raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/reg_bank.sv
// Flip-flop register bank: one write port, two registered read ports, bulk clear, written mask.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic [DEPTH-1:0] written
);

    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] written_d, written_q;
    logic             wr_en;

    // A write is effective only when not cleared and not aimed at a hardwired-zero r0.
    assign wr_en = we && !clr && !((ZERO_R0 != 0) && (waddr == '0));

    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        if (clr) begin
            regs_d    = '{default: '0};
            written_d = '0;
        end else if (wr_en) begin
            regs_d[waddr]    = wdata;
            written_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '{default: '0};
            written_q <= '0;
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
        end
    end

    assign written = written_q;

    reg_bank_rdport #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_rdport_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .re    (re_a),
        .raddr (raddr_a),
        .regs  (regs_q),
        .wr_en (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_a),
        .rvalid(rvalid_a)
    );

    reg_bank_rdport #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_rdport_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .re    (re_b),
        .raddr (raddr_b),
        .regs  (regs_q),
        .wr_en (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_b),
        .rvalid(rvalid_b)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: default 16x8 instance plus an 8x4 instance.
module tb_reg_bank;

    logic        clk;
    logic        reset, clr, we, re_a, re_b;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic [7:0]  written;

    logic        s_reset, s_clr, s_we, s_re_a, s_re_b;
    logic [1:0]  s_waddr, s_raddr_a, s_raddr_b;
    logic [7:0]  s_wdata, s_rdata_a, s_rdata_b;
    logic        s_rvalid_a, s_rvalid_b;
    logic [3:0]  s_written;

    int tests_run = 0;
    int tests_failed = 0;

    reg_bank dut (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .written(written)
    );

    reg_bank #(.WIDTH(8), .DEPTH(4), .ZERO_R0(1)) dut_s (
        .clk(clk), .reset(s_reset), .clr(s_clr), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .re_a(s_re_a), .raddr_a(s_raddr_a), .re_b(s_re_b), .raddr_b(s_raddr_b),
        .rdata_a(s_rdata_a), .rdata_b(s_rdata_b), .rvalid_a(s_rvalid_a),
        .rvalid_b(s_rvalid_b), .written(s_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; we = 0; re_a = 0; re_b = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        cycle();
        cycle();
        reset = 0;
        tests_run++;
        if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got a=%h b=%h va=%b vb=%b, want 0 0 0 0",
                     rdata_a, rdata_b, rvalid_a, rvalid_b);
        end
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(7 - i);
            cycle();
            tests_run++;
            if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_read[%0d]: got a=%h b=%h va=%b vb=%b, want 0 0 1 1",
                         i, rdata_a, rdata_b, rvalid_a, rvalid_b);
            end
        end
        idle();
        cycle();
        tests_run++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || written !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_idle: got va=%b vb=%b written=%h, want 0 0 00",
                     rvalid_a, rvalid_b, written);
        end
    endtask

    task automatic test_write_read();
        we = 1; waddr = 3; wdata = 16'hA5A5;
        cycle();
        we = 0; re_a = 1; raddr_a = 3;
        cycle();
        tests_run++;
        if (rdata_a !== 16'hA5A5 || rvalid_a !== 1'b1 || written !== 8'h08) begin
            tests_failed++;
            $display("FAIL write_read: got a=%h va=%b written=%h, want a5a5 1 08",
                     rdata_a, rvalid_a, written);
        end
        re_a = 0;
        cycle();
        tests_run++;
        if (rdata_a !== 16'hA5A5 || rvalid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_hold: got a=%h va=%b, want a5a5 0", rdata_a, rvalid_a);
        end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 5; wdata = 16'h1234;
        re_b = 1; raddr_b = 5; re_a = 1; raddr_a = 3;
        cycle();
        idle();
        tests_run++;
        if (rdata_b !== 16'h1234 || rvalid_b !== 1'b1 || rdata_a !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL bypass: got b=%h vb=%b a=%h, want 1234 1 a5a5",
                     rdata_b, rvalid_b, rdata_a);
        end
        tests_run++;
        if (written !== 8'h28) begin
            tests_failed++;
            $display("FAIL bypass_written: got %h, want 28", written);
        end
    endtask

    task automatic test_zero_r0();
        we = 1; waddr = 0; wdata = 16'hFFFF; re_a = 1; raddr_a = 0;
        cycle();
        tests_run++;
        if (rdata_a !== 16'h0 || rvalid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL r0_bypass: got a=%h va=%b, want 0 1", rdata_a, rvalid_a);
        end
        we = 0; re_b = 1; raddr_b = 0;
        cycle();
        idle();
        tests_run++;
        if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || written[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0_read: got a=%h b=%h written0=%b, want 0 0 0",
                     rdata_a, rdata_b, written[0]);
        end
    endtask

    task automatic test_same_addr();
        re_a = 1; re_b = 1; raddr_a = 5; raddr_b = 5;
        cycle();
        idle();
        tests_run++;
        if (rdata_a !== 16'h1234 || rdata_b !== 16'h1234) begin
            tests_failed++;
            $display("FAIL same_addr: got a=%h b=%h, want 1234 1234", rdata_a, rdata_b);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
            cycle();
        end
        we = 0; re_a = 1; raddr_a = 7; re_b = 1; raddr_b = 2;
        cycle();
        tests_run++;
        if (rdata_a !== 16'h1007 || rdata_b !== 16'h1002 || written !== 8'hFE) begin
            tests_failed++;
            $display("FAIL fill: got a=%h b=%h written=%h, want 1007 1002 fe",
                     rdata_a, rdata_b, written);
        end
        clr = 1; we = 1; waddr = 2; wdata = 16'hBEEF;
        re_a = 1; raddr_a = 2; re_b = 1; raddr_b = 7;
        cycle();
        idle();
        tests_run++;
        if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1
            || written !== 8'h00) begin
            tests_failed++;
            $display("FAIL clr_read: got a=%h b=%h va=%b vb=%b written=%h, want 0 0 1 1 00",
                     rdata_a, rdata_b, rvalid_a, rvalid_b, written);
        end
        for (int i = 0; i < 4; i++) begin
            re_a = 1; raddr_a = 3'(2 * i); re_b = 1; raddr_b = 3'(2 * i + 1);
            cycle();
            tests_run++;
            if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin
                tests_failed++;
                $display("FAIL clr_after[%0d]: got a=%h b=%h, want 0 0", i, rdata_a, rdata_b);
            end
        end
        idle();
    endtask

    task automatic test_reset_inflight();
        we = 1; waddr = 4; wdata = 16'h5555;
        cycle();
        we = 0; re_a = 1; raddr_a = 4; re_b = 1; raddr_b = 4;
        cycle();
        tests_run++;
        if (rdata_a !== 16'h5555 || rdata_b !== 16'h5555) begin
            tests_failed++;
            $display("FAIL pre_reset_read: got a=%h b=%h, want 5555 5555", rdata_a, rdata_b);
        end
        reset = 1; we = 1; waddr = 6; wdata = 16'h7777;
        cycle();
        reset = 0; idle();
        tests_run++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_a !== 16'h0 || rdata_b !== 16'h0
            || written !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_inflight: got a=%h b=%h va=%b vb=%b written=%h, want 0 0 0 0 00",
                     rdata_a, rdata_b, rvalid_a, rvalid_b, written);
        end
        re_a = 1; raddr_a = 6; re_b = 1; raddr_b = 4;
        cycle();
        idle();
        tests_run++;
        if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || rvalid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_override_we: got a=%h b=%h va=%b, want 0 0 1",
                     rdata_a, rdata_b, rvalid_a);
        end
    endtask

    task automatic test_small_params();
        s_reset = 1; s_clr = 0; s_we = 0; s_re_a = 0; s_re_b = 0;
        s_waddr = 0; s_wdata = 0; s_raddr_a = 0; s_raddr_b = 0;
        cycle();
        s_reset = 0;
        s_we = 1; s_waddr = 3; s_wdata = 8'h5A;
        cycle();
        s_waddr = 1; s_wdata = 8'hC3;
        cycle();
        s_we = 0; s_re_a = 1; s_raddr_a = 3; s_re_b = 1; s_raddr_b = 1;
        cycle();
        tests_run++;
        if (s_rdata_a !== 8'h5A || s_rdata_b !== 8'hC3 || s_written !== 4'b1010) begin
            tests_failed++;
            $display("FAIL small_rw: got a=%h b=%h written=%b, want 5a c3 1010",
                     s_rdata_a, s_rdata_b, s_written);
        end
        s_reset = 1; s_we = 1; s_waddr = 2; s_wdata = 8'h99; s_raddr_a = 2;
        cycle();
        s_reset = 0; s_we = 0; s_re_a = 0; s_re_b = 0;
        tests_run++;
        if (s_rvalid_a !== 1'b0 || s_rvalid_b !== 1'b0 || s_rdata_a !== 8'h0
            || s_rdata_b !== 8'h0 || s_written !== 4'b0000) begin
            tests_failed++;
            $display("FAIL small_reset: got a=%h b=%h va=%b vb=%b written=%b, want 0 0 0 0 0000",
                     s_rdata_a, s_rdata_b, s_rvalid_a, s_rvalid_b, s_written);
        end
    endtask

    initial begin
        s_reset = 1; s_clr = 0; s_we = 0; s_re_a = 0; s_re_b = 0;
        s_waddr = 0; s_wdata = 0; s_raddr_a = 0; s_raddr_b = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_r0();
        test_same_addr();
        test_clr();
        test_reset_inflight();
        test_small_params();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
